uart_rx_param: RTL and testbench

- Parametrised UART receiver; the next generation of the fixed 8N1 oversampled receiver used by the UARTrd/UARTstat path.
- Adds configurable data width, parity, stop-bit count and oversampling ratio.
- Adds an rx synchroniser, false-start rejection, and registered parity/framing error flags.
- Sits between the baud-rate tick generator (sTick) and the receive FIFO/accumulator mux.

---
 rtl/uart_rx_param.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop rx synchroniser, oversampled start/data/parity/stop
// sampling, false-start rejection, registered data word and parity/framing flags.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   sTick      - oversample enable, overSample pulses per bit period
//   rx         - serial line, idle high, asynchronous to clk
//   rxDoneTick - one-clk pulse when a frame completes (good or bad)
//   dOut       - last received word, LSB = first bit on the line
//   parityErr  - parity mismatch on the last frame (0 when parityMode = 0)
//   frameErr   - any stop-bit sample of the last frame was 0
module uart_rx_param #(
  parameter int unsigned dataBits   = 8,
  parameter int unsigned parityMode = 0,
  parameter int unsigned stopBits   = 1,
  parameter int unsigned overSample = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sTick,
  input  logic                rx,
  output logic                rxDoneTick,
  output logic [dataBits-1:0] dOut,
  output logic                parityErr,
  output logic                frameErr
);

  localparam int unsigned sW = $clog2(overSample);
  localparam int unsigned nW = (dataBits > 1) ? $clog2(dataBits) : 1;
  localparam logic [sW-1:0] sHalf = sW'(overSample / 2 - 1);
  localparam logic [sW-1:0] sLast = sW'(overSample - 1);
  localparam logic [nW-1:0] nLast = nW'(dataBits - 1);
  localparam logic          kLast = 1'(stopBits - 1);
  localparam logic          oddParity = (parityMode == 2);
  localparam logic          hasParity = (parityMode != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateType;

  stateType            state, stateNext;
  logic [sW-1:0]       s, sNext;
  logic [nW-1:0]       n, nNext;
  logic                k, kNext;
  logic [dataBits-1:0] shReg, shNext;
  logic                pBit, pBitNext;
  logic                fErrInt, fErrNext;
  logic                armed, armedNext;
  logic                rxMeta, rxS;
  logic [dataBits-1:0] dOutNext;
  logic                parErrNext, frameErrNext, doneNext;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      k          <= 1'b0;
      shReg      <= '0;
      pBit       <= 1'b0;
      fErrInt    <= 1'b0;
      armed      <= 1'b0;
      dOut       <= '0;
      parityErr  <= 1'b0;
      frameErr   <= 1'b0;
      rxDoneTick <= 1'b0;
    end else begin
      state      <= stateNext;
      s          <= sNext;
      n          <= nNext;
      k          <= kNext;
      shReg      <= shNext;
      pBit       <= pBitNext;
      fErrInt    <= fErrNext;
      armed      <= armedNext;
      dOut       <= dOutNext;
      parityErr  <= parErrNext;
      frameErr   <= frameErrNext;
      rxDoneTick <= doneNext;
    end
  end

  // Next-state and output logic.
  always_comb begin
    stateNext    = state;
    sNext        = s;
    nNext        = n;
    kNext        = k;
    shNext       = shReg;
    pBitNext     = pBit;
    fErrNext     = fErrInt;
    armedNext    = armed;
    dOutNext     = dOut;
    parErrNext   = parityErr;
    frameErrNext = frameErr;
    doneNext     = 1'b0;

    case (state)
      IDLE: begin
        // armed requires a high line after each completion, so a break is not a start.
        if (rxS) begin
          armedNext = 1'b1;
        end else if (armed) begin
          stateNext = START;
          sNext     = '0;
        end
      end

      START: begin
        if (sTick) begin
          if (s == sHalf) begin
            sNext = '0;
            if (!rxS) begin
              stateNext = DATA;
              nNext     = '0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            sNext = s + 1'b1;
          end
        end
      end

      DATA: begin
        if (sTick) begin
          if (s == sLast) begin
            sNext  = '0;
            shNext = {rxS, shReg[dataBits-1:1]};
            if (n == nLast) begin
              kNext     = 1'b0;
              stateNext = hasParity ? PARITY : STOP;
            end else begin
              nNext = n + 1'b1;
            end
          end else begin
            sNext = s + 1'b1;
          end
        end
      end

      PARITY: begin
        if (sTick) begin
          if (s == sLast) begin
            sNext     = '0;
            pBitNext  = rxS;
            kNext     = 1'b0;
            stateNext = STOP;
          end else begin
            sNext = s + 1'b1;
          end
        end
      end

      STOP: begin
        if (sTick) begin
          if (s == sLast) begin
            sNext = '0;
            if (k == kLast) begin
              // Final stop sample folds straight into the registered flags.
              stateNext    = IDLE;
              dOutNext     = shReg;
              frameErrNext = fErrInt | ~rxS;
              parErrNext   = hasParity && (((^shReg) ^ pBit) != oddParity);
              doneNext     = 1'b1;
              fErrNext     = 1'b0;
              armedNext    = 1'b0;
              kNext        = 1'b0;
              nNext        = '0;
            end else begin
              fErrNext = fErrInt | ~rxS;
              kNext    = k + 1'b1;
            end
          end else begin
            sNext = s + 1'b1;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1 x16, 8E1 x16, 7O2 x8 with sTick every 3 clk)
// driven by a vector table plus directed glitch, break and mid-frame reset sequences.
module tb_uart_rx_param;

  logic       clk;
  logic       reset;
  logic       tickA, tickB, tickC;
  logic       rxA, rxB, rxC;
  logic       doneA, doneB, doneC;
  logic [7:0] dOutA, dOutB;
  logic [6:0] dOutC;
  logic       parA, parB, parC;
  logic       frmA, frmB, frmC;

  int total = 0;
  int bad   = 0;
  int cntA  = 0;
  int cntB  = 0;
  int cntC  = 0;

  uart_rx_param dutA (
    .clk(clk), .reset(reset), .sTick(tickA), .rx(rxA),
    .rxDoneTick(doneA), .dOut(dOutA), .parityErr(parA), .frameErr(frmA)
  );

  uart_rx_param #(.parityMode(1)) dutB (
    .clk(clk), .reset(reset), .sTick(tickB), .rx(rxB),
    .rxDoneTick(doneB), .dOut(dOutB), .parityErr(parB), .frameErr(frmB)
  );

  uart_rx_param #(.dataBits(7), .parityMode(2), .stopBits(2), .overSample(8)) dutC (
    .clk(clk), .reset(reset), .sTick(tickC), .rx(rxC),
    .rxDoneTick(doneC), .dOut(dOutC), .parityErr(parC), .frameErr(frmC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses per instance.
  always @(negedge clk) begin
    if (doneA) cntA <= cntA + 1;
    if (doneB) cntB <= cntB + 1;
    if (doneC) cntC <= cntC + 1;
  end

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    int         expD;
    int         expP;
    int         expF;
  } vecT;

  vecT vecs[13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int osOf(input int d);
    return (d == 2) ? 8 : 16;
  endfunction

  function automatic int gapOf(input int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic int dbOf(input int d);
    return (d == 2) ? 7 : 8;
  endfunction

  function automatic int sbOf(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic setLine(input int d, input logic v);
    case (d)
      0: rxA = v;
      1: rxB = v;
      default: rxC = v;
    endcase
  endtask

  task automatic setTick(input int d, input logic v);
    case (d)
      0: tickA = v;
      1: tickB = v;
      default: tickC = v;
    endcase
  endtask

  // One bit period: line held, overSample ticks spaced gap clocks apart.
  task automatic sendBit(input int d, input logic v);
    setLine(d, v);
    repeat (osOf(d)) begin
      setTick(d, 1'b1);
      @(negedge clk);
      setTick(d, 1'b0);
      repeat (gapOf(d) - 1) @(negedge clk);
    end
  endtask

  task automatic idleBits(input int d, input int nb);
    repeat (nb) sendBit(d, 1'b1);
  endtask

  task automatic sendFrame(input int d, input logic [8:0] data, input logic pbit,
                           input logic [1:0] stops);
    sendBit(d, 1'b0);
    for (int i = 0; i < dbOf(d); i++) sendBit(d, data[i]);
    if (d != 0) sendBit(d, pbit);
    for (int i = 0; i < sbOf(d); i++) sendBit(d, stops[i]);
  endtask

  task automatic readOut(input int d, output int dv, output int pv, output int fv,
                         output int cv);
    case (d)
      0: begin dv = int'(dOutA); pv = int'(parA); fv = int'(frmA); cv = cntA; end
      1: begin dv = int'(dOutB); pv = int'(parB); fv = int'(frmB); cv = cntB; end
      default: begin dv = int'(dOutC); pv = int'(parC); fv = int'(frmC); cv = cntC; end
    endcase
  endtask

  initial begin
    int c0, dv, pv, fv, cv;

    reset = 1'b1;
    rxA = 1'b1; rxB = 1'b1; rxC = 1'b1;
    tickA = 1'b0; tickB = 1'b0; tickC = 1'b0;

    vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 'hA5, 0, 0};
    vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, 'h00, 0, 0};
    vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 'hFF, 0, 0};
    vecs[3]  = '{1, 9'h003, 1'b0, 2'b11, 'h03, 0, 0};
    vecs[4]  = '{1, 9'h003, 1'b1, 2'b11, 'h03, 1, 0};
    vecs[5]  = '{1, 9'h080, 1'b1, 2'b11, 'h80, 0, 0};
    vecs[6]  = '{1, 9'h080, 1'b0, 2'b11, 'h80, 1, 0};
    vecs[7]  = '{2, 9'h055, 1'b1, 2'b11, 'h55, 0, 0};
    vecs[8]  = '{2, 9'h055, 1'b1, 2'b01, 'h55, 0, 1};
    vecs[9]  = '{2, 9'h02A, 1'b0, 2'b11, 'h2A, 0, 0};
    vecs[10] = '{2, 9'h003, 1'b0, 2'b11, 'h03, 1, 0};
    vecs[11] = '{2, 9'h001, 1'b0, 2'b10, 'h01, 0, 1};
    vecs[12] = '{2, 9'h040, 1'b1, 2'b11, 'h40, 1, 0};

    repeat (3) @(negedge clk);
    check("reset dOutA", int'(dOutA), 0);
    check("reset doneA", int'(doneA), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset dOutB", int'(dOutB), 0);
    check("post-reset dOutC", int'(dOutC), 0);
    check("post-reset frmA", int'(frmA), 0);
    check("post-reset parB", int'(parB), 0);
    check("post-reset frmC", int'(frmC), 0);

    idleBits(0, 1);
    idleBits(1, 1);
    idleBits(2, 1);

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      readOut(vecs[i].dut, dv, pv, fv, c0);
      sendFrame(vecs[i].dut, vecs[i].data, vecs[i].pbit, vecs[i].stops);
      idleBits(vecs[i].dut, 2);
      readOut(vecs[i].dut, dv, pv, fv, cv);
      check($sformatf("v%0d pulses", i), cv - c0, 1);
      check($sformatf("v%0d dOut", i), dv, vecs[i].expD);
      check($sformatf("v%0d parityErr", i), pv, vecs[i].expP);
      check($sformatf("v%0d frameErr", i), fv, vecs[i].expF);
    end

    // Break: bad stop bit, line held low 3 bit times, then high long enough for a bogus frame.
    c0 = cntA;
    sendFrame(0, 9'h05A, 1'b0, 2'b00);
    repeat (3) sendBit(0, 1'b0);
    check("break pulses while low", cntA - c0, 1);
    idleBits(0, 12);
    check("break pulses", cntA - c0, 1);
    check("break dOut", int'(dOutA), 'h5A);
    check("break frameErr", int'(frmA), 1);
    check("break parityErr", int'(parA), 0);

    // Glitch: low for 3 sTick periods only.
    c0 = cntA;
    setLine(0, 1'b0);
    repeat (3) begin
      tickA = 1'b1;
      @(negedge clk);
      tickA = 1'b0;
      @(negedge clk);
    end
    idleBits(0, 3);
    check("glitch pulses", cntA - c0, 0);
    check("glitch dOut held", int'(dOutA), 'h5A);
    check("glitch frameErr held", int'(frmA), 1);
    sendFrame(0, 9'h03C, 1'b0, 2'b11);
    idleBits(0, 2);
    check("after glitch pulses", cntA - c0, 1);
    check("after glitch dOut", int'(dOutA), 'h3C);
    check("after glitch frameErr", int'(frmA), 0);

    // Mid-frame reset: start + 4 data bits of 0xFF, then reset, then a clean 0x81.
    c0 = cntA;
    sendBit(0, 1'b0);
    repeat (4) sendBit(0, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("in reset dOutA", int'(dOutA), 0);
    check("in reset frmA", int'(frmA), 0);
    check("in reset doneA", int'(doneA), 0);
    check("in reset dOutB", int'(dOutB), 0);
    check("in reset dOutC", int'(dOutC), 0);
    check("in reset parC", int'(parC), 0);
    reset = 1'b0;
    idleBits(0, 12);
    check("after reset pulses", cntA - c0, 0);
    check("after reset dOutA", int'(dOutA), 0);
    sendFrame(0, 9'h081, 1'b0, 2'b11);
    idleBits(0, 2);
    check("reset seq pulses", cntA - c0, 1);
    check("reset seq dOut", int'(dOutA), 'h81);
    check("reset seq frameErr", int'(frmA), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
